// File: rtl/bcd_calc_pkg.sv
// Shared constants for the BCD calculator front end: key codes, entry-state
// encoding and the bit layout of the 17-bit operand word.
package bcd_calc_pkg;

  localparam logic [3:0] KEY_PLUS  = 4'd10;
  localparam logic [3:0] KEY_MINUS = 4'd11;
  localparam logic [3:0] KEY_EQ    = 4'd12;
  localparam logic [3:0] KEY_CLR   = 4'd13;
  localparam logic [3:0] KEY_BS    = 4'd14;

  typedef enum logic [1:0] {
    ST_ENTER_A = 2'b00,
    ST_ENTER_B = 2'b01,
    ST_DONE    = 2'b10
  } entry_state_t;

  localparam int OP_BIT  = 16;
  localparam int A10_LSB = 12;
  localparam int A1_LSB  = 8;
  localparam int B10_LSB = 4;
  localparam int B1_LSB  = 0;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/entry_holdoff_timer.sv
// Loadable down-counter gating key acceptance; key_ready is low while the
// count is non-zero, giving exactly HOLDOFF dead cycles after each load.
module entry_holdoff_timer #(
  parameter int HOLDOFF   = 16,
  parameter int HOLDOFF_W = 5
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic load,
  output logic key_ready
);

  logic [HOLDOFF_W-1:0] cnt;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET)
      cnt <= '0;
    else if (load)
      cnt <= HOLDOFF_W'(HOLDOFF);
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign key_ready = (cnt == '0);

endmodule

// File: rtl/bcd_operand_entry.sv
// Keyed entry of two 2-digit BCD operands and an operator, emitting the
// 17-bit switch-word layout. Build with ENTRY_BACKSPACE_EN for backspace.
module bcd_operand_entry
  import bcd_calc_pkg::*;
#(
  parameter int HOLDOFF   = 16,
  parameter int HOLDOFF_W = 5
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_ready,
  output logic [16:0] OPERANDS,
  output logic        op_valid,
  output logic [1:0]  entry_state,
  output logic        key_err
);

  entry_state_t state;
  logic [3:0]   a10, a1, b10, b1;
  logic         op;
  logic [1:0]   cnt_a, cnt_b;
  logic         accept;
  logic         op_sel;

  assign accept = key_valid & key_ready;
  assign op_sel = (key_code == KEY_MINUS);

  entry_holdoff_timer #(
    .HOLDOFF   (HOLDOFF),
    .HOLDOFF_W (HOLDOFF_W)
  ) u_holdoff (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .load      (accept),
    .key_ready (key_ready)
  );

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state    <= ST_ENTER_A;
      {a10, a1, b10, b1} <= '0;
      op       <= 1'b0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      op_valid <= 1'b0;
      key_err  <= 1'b0;
    end else begin
      op_valid <= 1'b0;
      key_err  <= 1'b0;
      if (accept) begin
        if (is_digit(key_code)) begin
          unique case (state)
            ST_ENTER_A:
              if (cnt_a < 2'd2) begin
                a10 <= a1; a1 <= key_code; cnt_a <= cnt_a + 1'b1;
              end else key_err <= 1'b1;
            ST_ENTER_B:
              if (cnt_b < 2'd2) begin
                b10 <= b1; b1 <= key_code; cnt_b <= cnt_b + 1'b1;
              end else key_err <= 1'b1;
            default: begin
              // a digit after a finished entry starts a fresh calculation
              {a10, b10, b1} <= '0;
              a1    <= key_code;
              op    <= 1'b0;
              cnt_a <= 2'd1;
              cnt_b <= '0;
              state <= ST_ENTER_A;
            end
          endcase
        end else begin
          case (key_code)
            KEY_PLUS, KEY_MINUS:
              unique case (state)
                ST_ENTER_A: begin op <= op_sel; state <= ST_ENTER_B; end
                ST_ENTER_B:
                  if (cnt_b == '0) op <= op_sel;
                  else key_err <= 1'b1;
                default: begin
                  {b10, b1} <= '0;
                  cnt_b <= '0;
                  op    <= op_sel;
                  state <= ST_ENTER_B;
                end
              endcase
            KEY_EQ:
              if (state == ST_ENTER_A) key_err <= 1'b1;
              else begin
                op_valid <= 1'b1;
                state    <= ST_DONE;
              end
            KEY_CLR: begin
              {a10, a1, b10, b1} <= '0;
              op    <= 1'b0;
              cnt_a <= '0;
              cnt_b <= '0;
              state <= ST_ENTER_A;
            end
            KEY_BS: begin
`ifdef ENTRY_BACKSPACE_EN
              unique case (state)
                ST_ENTER_A:
                  if (cnt_a != '0) begin
                    a1 <= a10; a10 <= '0; cnt_a <= cnt_a - 1'b1;
                  end else key_err <= 1'b1;
                ST_ENTER_B:
                  if (cnt_b != '0) begin
                    b1 <= b10; b10 <= '0; cnt_b <= cnt_b - 1'b1;
                  end else state <= ST_ENTER_A;
                default: key_err <= 1'b1;
              endcase
`else
              key_err <= 1'b1;
`endif
            end
            default: key_err <= 1'b1;
          endcase
        end
      end
    end
  end

  always_comb begin
    OPERANDS = '0;
    OPERANDS[OP_BIT]         = op;
    OPERANDS[A10_LSB +: 4]   = a10;
    OPERANDS[A1_LSB  +: 4]   = a1;
    OPERANDS[B10_LSB +: 4]   = b10;
    OPERANDS[B1_LSB  +: 4]   = b1;
  end

  assign entry_state = state;

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Directed self-checking bench for bcd_operand_entry with HOLDOFF=4.
module tb_bcd_operand_entry;
  localparam int HOLDOFF = 4;

  logic        CLOCK_50 = 1'b0;
  logic        RESET;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [16:0] OPERANDS;
  logic        op_valid;
  logic [1:0]  entry_state;
  logic        key_err;

  int checks = 0;
  int fails  = 0;
  int opv_cnt = 0;
  int err_cnt = 0;
  int acc_cnt = 0;
  int both_cnt = 0;

  bcd_operand_entry #(.HOLDOFF(HOLDOFF), .HOLDOFF_W(3)) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET       (RESET),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .OPERANDS    (OPERANDS),
    .op_valid    (op_valid),
    .entry_state (entry_state),
    .key_err     (key_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (op_valid) opv_cnt++;
    if (key_err) err_cnt++;
    if (key_valid && key_ready) acc_cnt++;
    if (op_valid && key_err) both_cnt++;
  end

  task automatic send_key(input logic [3:0] c, output logic err, output logic opv);
    int n = 0;
    while (!key_ready && n < 100) begin
      @(posedge CLOCK_50); #1; n++;
    end
    if (!key_ready) begin
      checks++; fails++;
      $display("FAIL ready_timeout: key_ready=%b required 1", key_ready);
    end
    key_valid = 1'b1; key_code = c;
    @(posedge CLOCK_50); #1;
    key_valid = 1'b0;
    err = key_err; opv = op_valid;
  endtask

  task automatic test_reset;
    checks++;
    if ({OPERANDS, op_valid, key_err, entry_state, key_ready} !== {17'h0, 1'b0, 1'b0, 2'b00, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: OPERANDS=%h opv=%b err=%b st=%b rdy=%b required 0/0/0/00/1",
               OPERANDS, op_valid, key_err, entry_state, key_ready);
    end
  endtask

  task automatic test_basic_entry;
    logic e, v;
    int p0;
    int low = 0;
    send_key(4'd4, e, v);
    for (int i = 0; i < HOLDOFF; i++) begin
      if (!key_ready) low++;
      @(posedge CLOCK_50); #1;
    end
    checks++;
    if (low !== HOLDOFF || key_ready !== 1'b1) begin
      fails++;
      $display("FAIL holdoff_len: low=%0d rdy_after=%b required %0d/1", low, key_ready, HOLDOFF);
    end
    send_key(4'd7, e, v);
    send_key(4'd10, e, v);
    send_key(4'd2, e, v);
    send_key(4'd5, e, v);
    p0 = opv_cnt;
    send_key(4'd12, e, v);
    checks++;
    if (v !== 1'b1 || e !== 1'b0 || OPERANDS !== 17'h04725 || entry_state !== 2'b10) begin
      fails++;
      $display("FAIL add_entry: opv=%b err=%b OPERANDS=%h st=%b required 1/0/04725/10", v, e, OPERANDS, entry_state);
    end
    @(posedge CLOCK_50); #1;
    checks++;
    if (op_valid !== 1'b0 || opv_cnt - p0 !== 1 || OPERANDS !== 17'h04725) begin
      fails++;
      $display("FAIL opv_pulse: opv=%b pulses=%0d OPERANDS=%h required 0/1/04725", op_valid, opv_cnt - p0, OPERANDS);
    end
  endtask

  task automatic test_sub_entry;
    logic e, v;
    int p0 = opv_cnt;
    send_key(4'd9, e, v);
    checks++;
    if (OPERANDS !== 17'h00900 || entry_state !== 2'b00) begin
      fails++;
      $display("FAIL done_digit_restart: OPERANDS=%h st=%b required 00900/00", OPERANDS, entry_state);
    end
    send_key(4'd3, e, v);
    send_key(4'd11, e, v);
    send_key(4'd8, e, v);
    send_key(4'd12, e, v);
    @(posedge CLOCK_50); #1;
    checks++;
    if (OPERANDS !== 17'h19308 || opv_cnt - p0 !== 1) begin
      fails++;
      $display("FAIL sub_entry: OPERANDS=%h pulses=%0d required 19308/1", OPERANDS, opv_cnt - p0);
    end
    p0 = opv_cnt;
    send_key(4'd12, e, v);
    checks++;
    if (v !== 1'b1 || OPERANDS !== 17'h19308 || entry_state !== 2'b10) begin
      fails++;
      $display("FAIL done_restrobe: opv=%b OPERANDS=%h st=%b required 1/19308/10", v, OPERANDS, entry_state);
    end
    send_key(4'd10, e, v);
    checks++;
    if (OPERANDS !== 17'h09300 || entry_state !== 2'b01) begin
      fails++;
      $display("FAIL done_operator: OPERANDS=%h st=%b required 09300/01", OPERANDS, entry_state);
    end
  endtask

  task automatic test_errors;
    logic e, v;
    int p0;
    send_key(4'd13, e, v);
    send_key(4'd1, e, v);
    send_key(4'd2, e, v);
    send_key(4'd3, e, v);
    checks++;
    if (e !== 1'b1 || v !== 1'b0 || OPERANDS !== 17'h01200) begin
      fails++;
      $display("FAIL third_digit: err=%b opv=%b OPERANDS=%h required 1/0/01200", e, v, OPERANDS);
    end
    @(posedge CLOCK_50); #1;
    checks++;
    if (key_err !== 1'b0) begin
      fails++;
      $display("FAIL err_pulse_len: err=%b required 0", key_err);
    end
    p0 = opv_cnt;
    send_key(4'd12, e, v);
    @(posedge CLOCK_50); #1;
    checks++;
    if (e !== 1'b1 || opv_cnt !== p0 || entry_state !== 2'b00 || OPERANDS !== 17'h01200) begin
      fails++;
      $display("FAIL eq_in_a: err=%b pulses=%0d st=%b OPERANDS=%h required 1/0/00/01200", e, opv_cnt - p0, entry_state, OPERANDS);
    end
    send_key(4'd15, e, v);
    checks++;
    if (e !== 1'b1 || OPERANDS !== 17'h01200) begin
      fails++;
      $display("FAIL reserved_code: err=%b OPERANDS=%h required 1/01200", e, OPERANDS);
    end
    send_key(4'd11, e, v);
    send_key(4'd10, e, v);
    checks++;
    if (e !== 1'b0 || OPERANDS !== 17'h01200 || entry_state !== 2'b01) begin
      fails++;
      $display("FAIL op_overwrite: err=%b OPERANDS=%h st=%b required 0/01200/01", e, OPERANDS, entry_state);
    end
    send_key(4'd7, e, v);
    send_key(4'd11, e, v);
    checks++;
    if (e !== 1'b1 || OPERANDS !== 17'h01207) begin
      fails++;
      $display("FAIL op_after_b: err=%b OPERANDS=%h required 1/01207", e, OPERANDS);
    end
  endtask

  task automatic test_continuous;
    logic e, v;
    int a0, e0;
    send_key(4'd13, e, v);
    while (!key_ready) begin @(posedge CLOCK_50); #1; end
    a0 = acc_cnt; e0 = err_cnt;
    key_valid = 1'b1; key_code = 4'd5;
    for (int i = 0; i < 3 * (HOLDOFF + 1); i++) begin
      @(posedge CLOCK_50); #1;
    end
    key_valid = 1'b0;
    @(posedge CLOCK_50); #1;
    checks++;
    if (acc_cnt - a0 !== 3 || err_cnt - e0 !== 1 || OPERANDS !== 17'h05500) begin
      fails++;
      $display("FAIL held_valid: accepts=%0d errs=%0d OPERANDS=%h required 3/1/05500", acc_cnt - a0, err_cnt - e0, OPERANDS);
    end
  endtask

  task automatic test_reset_mid;
    logic e, v;
    send_key(4'd6, e, v);
    send_key(4'd10, e, v);
    send_key(4'd1, e, v);
    send_key(4'd12, e, v);
    #2 RESET = 1'b1;
    #1;
    checks++;
    if ({OPERANDS, op_valid, entry_state, key_ready} !== {17'h0, 1'b0, 2'b00, 1'b1}) begin
      fails++;
      $display("FAIL async_reset: OPERANDS=%h opv=%b st=%b rdy=%b required 0/0/00/1", OPERANDS, op_valid, entry_state, key_ready);
    end
    @(posedge CLOCK_50); #1;
    RESET = 1'b0;
    @(posedge CLOCK_50); #1;
    checks++;
    if (key_ready !== 1'b1 || OPERANDS !== 17'h0) begin
      fails++;
      $display("FAIL ready_after_reset: rdy=%b OPERANDS=%h required 1/0", key_ready, OPERANDS);
    end
    send_key(4'd3, e, v);
    send_key(4'd4, e, v);
    send_key(4'd11, e, v);
    send_key(4'd5, e, v);
    send_key(4'd13, e, v);
    checks++;
    if (e !== 1'b0 || OPERANDS !== 17'h0 || entry_state !== 2'b00) begin
      fails++;
      $display("FAIL clear_mid_b: err=%b OPERANDS=%h st=%b required 0/00000/00", e, OPERANDS, entry_state);
    end
  endtask

  task automatic test_backspace;
    logic e, v;
    send_key(4'd13, e, v);
    send_key(4'd6, e, v);
    send_key(4'd1, e, v);
    send_key(4'd14, e, v);
`ifdef ENTRY_BACKSPACE_EN
    checks++;
    if (e !== 1'b0 || OPERANDS !== 17'h00600) begin
      fails++;
      $display("FAIL bs_a: err=%b OPERANDS=%h required 0/00600", e, OPERANDS);
    end
    send_key(4'd10, e, v);
    send_key(4'd14, e, v);
    checks++;
    if (e !== 1'b0 || OPERANDS !== 17'h00600 || entry_state !== 2'b00) begin
      fails++;
      $display("FAIL bs_b_empty: err=%b OPERANDS=%h st=%b required 0/00600/00", e, OPERANDS, entry_state);
    end
`else
    checks++;
    if (e !== 1'b1 || OPERANDS !== 17'h06100 || entry_state !== 2'b00) begin
      fails++;
      $display("FAIL bs_disabled: err=%b OPERANDS=%h st=%b required 1/06100/00", e, OPERANDS, entry_state);
    end
`endif
  endtask

  initial begin
    RESET = 1'b1; key_valid = 1'b0; key_code = 4'd0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    test_reset();
    RESET = 1'b0;
    @(posedge CLOCK_50); #1;
    test_reset();
    test_basic_entry();
    test_sub_entry();
    test_errors();
    test_continuous();
    test_reset_mid();
    test_backspace();
    checks++;
    if (both_cnt !== 0) begin
      fails++;
      $display("FAIL err_opv_overlap: cycles=%0d required 0", both_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
